bus_fabric: RTL
===============

Name: bus_fabric

Overview:
- Parametrised single-master data-bus interconnect; successor to the fixed three-way decode in the SoC top level.
- Decodes the upper address bits to one of NUM_SLAVES slaves and forwards strobes.
- Tracks one outstanding transaction and steers the routed slave's data, ack and retry back to the CPU data port.
- Adds behaviour the fixed decode lacks: an unmapped-address error response, a slave timeout, and busy-retry of overlapping strobes.

Parameters:
ADDR_BITS, 28, master address width
SEL_BITS, 2, number of top address bits used as the slave index
NUM_SLAVES, 4, number of slave ports (at most 2**SEL_BITS)
SLAVE_MASK, 4'b1101, bit i set means slave i is mapped; width NUM_SLAVES
WORD_BITS, 32, data width
TIMEOUT, 255, cycles waited for a slave ack before an error response (at least 1)

Ports:
clock  in  1  bus clock
reset_n  in  1  asynchronous active-low reset
addr  in  ADDR_BITS  master address
in  in  WORD_BITS  master write data
select  in  WORD_BITS/8  byte enables
write  in  1  write request
strobe  in  1  master request
out  out  WORD_BITS  read data returned to master
ack  out  1  transaction complete
retry  out  1  reissue request
error  out  1  qualifies ack: bus error
slave_addr  out  ADDR_BITS-SEL_BITS  addr low bits, broadcast to all slaves
slave_in  out  WORD_BITS  broadcast copy of in
slave_select  out  WORD_BITS/8  broadcast copy of select
slave_write  out  1  broadcast copy of write
slave_strobe  out  NUM_SLAVES  one-hot strobe
slave_out  in  NUM_SLAVES*WORD_BITS  slave read data; slave i occupies bits [i*WORD_BITS +: WORD_BITS]
slave_ack  in  NUM_SLAVES  per-slave ack
slave_retry  in  NUM_SLAVES  per-slave retry
error_count  out  8  saturating count of error responses

Behaviour:
- Reset (async assert, sync release): state IDLE; route register = 0; timer = 0; error_count = 0.
  - During reset, out, ack, retry, error and slave_strobe are all 0.
- Decode: idx = addr[ADDR_BITS-1 -: SEL_BITS]. The address is mapped when idx < NUM_SLAVES and SLAVE_MASK[idx] = 1.
- The slave_* broadcast outputs are combinational copies of the master inputs.

State machine:
- IDLE:
  - Mapped strobe: slave_strobe[idx] = 1 in the same cycle. Latch the one-hot route, clear the timer, go to WAIT.
  - Unmapped strobe: no slave strobed; go to ERR.
- WAIT (route = r):
  - slave_ack[r] = 1: combinationally drive ack = 1, error = 0, out = slave_out[r].
    - A concurrent master strobe is decoded exactly as in IDLE (back-to-back, zero bubble).
    - Otherwise return to IDLE.
  - slave_retry[r] = 1 (ack low): drive retry = 1 and go to IDLE; the master reissues the request.
  - ack and retry both high from the routed slave: ack wins; retry is suppressed.
  - Master strobe with no routed ack: drive retry = 1 in that cycle. The request is not forwarded and state is unchanged.
  - Timer increments each cycle with no ack and no retry. On reaching TIMEOUT, go to ERR and clear the route.
- ERR: lasts one cycle. Drive ack = 1, error = 1, out = 0; increment error_count, saturating at 255.
  - A strobe in this cycle gets retry = 1 and is not forwarded.
  - Next state is IDLE.
- Signals from unrouted slaves are ignored, including a late ack after a timeout (no spurious master ack).
- out = 0 whenever ack is 0.
- Latency:
  - Mapped access: slave latency + 0 cycles.
  - Unmapped access: ack/error one cycle after the strobe.
  - Timeout: ack/error TIMEOUT+1 cycles after the strobe.
- Reset asserted mid-transaction: immediate return to IDLE; the pending ack is discarded.

Test Plan:
- Read slave 0 (addr=28'h0000010); slave 0 acks 2 cycles later with 32'hDEADBEEF -> slave_strobe=4'b0001 in the strobe cycle; ack=1, error=0, out=32'hDEADBEEF in the ack cycle.
- Strobe to unmapped slave 1 (addr=28'h4000000) -> no slave_strobe; the next cycle gives ack=1, error=1, out=0, and error_count becomes 1.
- Strobe to slave 3 that never acks, TIMEOUT=255 -> ack=1, error=1 exactly 256 cycles after the strobe. A slave_ack[3] 10 cycles later produces no master ack.
- Slave 2 acks while the master strobes slave 0 in the same cycle -> ack for slave 2, slave_strobe=4'b0001 in that same cycle, and the next ack comes from slave 0.
- Master strobes again while slave 2 is pending -> retry=1 and slave_strobe=0 for that cycle. A slave_retry[2] pulse gives master retry=1 and state IDLE.
- reset_n pulsed low while WAIT on slave 0 -> outputs go to 0 immediately. A subsequent slave_ack[0] is ignored, and error_count = 0.

Source files
------------

// File: rtl/bus_fabric.sv
// bus_fabric: single-master data-bus interconnect.
// Decodes the top address bits to one of NUM_SLAVES slaves and keeps one
// transaction outstanding. Data, ack and retry come back from the routed
// slave only. The fabric adds three responses of its own:
//   - an error response for unmapped addresses,
//   - an error response when a slave does not ack within TIMEOUT cycles,
//   - a retry for a master strobe that overlaps a pending transaction.
module bus_fabric #(
    parameter int                  ADDR_BITS  = 28,
    parameter int                  SEL_BITS   = 2,
    parameter int                  NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES-1:0] SLAVE_MASK = 4'b1101,
    parameter int                  WORD_BITS  = 32,
    parameter int                  TIMEOUT    = 255
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [ADDR_BITS-1:0]            addr,
    input  logic [WORD_BITS-1:0]            in,
    input  logic [WORD_BITS/8-1:0]          select,
    input  logic                            write,
    input  logic                            strobe,
    output logic [WORD_BITS-1:0]            out,
    output logic                            ack,
    output logic                            retry,
    output logic                            error,
    output logic [ADDR_BITS-SEL_BITS-1:0]   slave_addr,
    output logic [WORD_BITS-1:0]            slave_in,
    output logic [WORD_BITS/8-1:0]          slave_select,
    output logic                            slave_write,
    output logic [NUM_SLAVES-1:0]           slave_strobe,
    input  logic [NUM_SLAVES*WORD_BITS-1:0] slave_out,
    input  logic [NUM_SLAVES-1:0]           slave_ack,
    input  logic [NUM_SLAVES-1:0]           slave_retry,
    output logic [7:0]                      error_count
);

    // Timer only has to count up to TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   route_q, route_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic [SEL_BITS-1:0]     idx;
    logic                    mapped;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic                    rt_ack;
    logic                    rt_retry;
    logic [WORD_BITS-1:0]    rt_data;
    logic                    take_req;
    logic                    fwd;
    logic                    ack_c;
    logic                    err_c;
    logic                    retry_c;
    logic [WORD_BITS-1:0]    data_c;

    // Broadcast copies of the master request go to every slave unchanged.
    assign slave_addr   = addr[ADDR_BITS-SEL_BITS-1:0];
    assign slave_in     = in;
    assign slave_select = select;
    assign slave_write  = write;

    assign idx = addr[ADDR_BITS-1 -: SEL_BITS];

    // Address decode: an index beyond NUM_SLAVES or with a clear mask bit is unmapped.
    always_comb begin
        dec_onehot = '0;
        mapped     = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == SEL_BITS'(i) && SLAVE_MASK[i]) begin
                dec_onehot[i] = 1'b1;
                mapped        = 1'b1;
            end
        end
    end

    // Only the routed slave is listened to; everything else is masked off.
    always_comb begin
        rt_ack   = |(slave_ack & route_q);
        rt_retry = |(slave_retry & route_q);
        rt_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (route_q[i]) begin
                rt_data = rt_data | slave_out[i*WORD_BITS +: WORD_BITS];
            end
        end
    end

    // Next-state and master-side response logic.
    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        timer_d   = timer_q;
        err_cnt_d = err_cnt_q;
        take_req  = 1'b0;
        fwd       = 1'b0;
        ack_c     = 1'b0;
        err_c     = 1'b0;
        retry_c   = 1'b0;
        data_c    = '0;

        case (state_q)
            ST_IDLE: begin
                take_req = strobe;
            end
            ST_WAIT: begin
                if (rt_ack) begin
                    // Ack has priority over a simultaneous slave retry.
                    ack_c    = 1'b1;
                    data_c   = rt_data;
                    state_d  = ST_IDLE;
                    route_d  = '0;
                    take_req = strobe;
                end else if (rt_retry) begin
                    retry_c = 1'b1;
                    state_d = ST_IDLE;
                    route_d = '0;
                end else begin
                    // Overlapping strobe is bounced; the transaction keeps ageing.
                    retry_c = strobe;
                    if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                        route_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ST_ERR: begin
                ack_c     = 1'b1;
                err_c     = 1'b1;
                retry_c   = strobe;
                state_d   = ST_IDLE;
                err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end
            default: begin
                state_d = ST_IDLE;
                route_d = '0;
            end
        endcase

        // A new request is accepted from IDLE or in the same cycle a pending one acks.
        if (take_req) begin
            if (mapped) begin
                fwd     = 1'b1;
                route_d = dec_onehot;
                timer_d = '0;
                state_d = ST_WAIT;
            end else begin
                state_d = ST_ERR;
            end
        end
    end

    // Strobe is suppressed while reset is held even though decode is combinational.
    assign slave_strobe = (fwd && reset_n) ? dec_onehot : '0;
    assign ack          = ack_c;
    assign error        = err_c;
    assign retry        = retry_c;
    assign out          = data_c;
    assign error_count  = err_cnt_q;

    // Transaction state, route, timeout timer and error counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            route_q   <= '0;
            timer_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            route_q   <= route_d;
            timer_q   <= timer_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
